// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start detect, majority-vote
// bit sampling, LSB-first deserialisation, parity and stop checks.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [5:0]            edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [2:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  bad_q, bad_d;
  logic                  armed_q, armed_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic [5:0]            presc_q, presc_d;

  logic [5:0] half;
  logic       last;
  logic       mid;
  logic       bitv;
  logic       exp_par;

  assign half    = {1'b0, presc_q[5:1]};
  assign last    = (edge_q == presc_q - 6'd1);
  assign mid     = (edge_q == half + 6'd1);
  assign bitv    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2])
                 | (smp_q[1] & smp_q[2]);
  assign exp_par = ptyp_q ? ~^shift_q : ^shift_q;

  // Next-state: bit timing, sampling and frame sequencing
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    pdata_d = pdata_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    serr_d  = 1'b0;
    bad_d   = bad_q;
    armed_d = armed_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    presc_d = presc_q;

    if (state_q != S_IDLE) begin
      edge_d = last ? 6'd0 : edge_q + 6'd1;
      if (edge_q == half - 6'd2) smp_d[0] = RX_IN;
      if (edge_q == half - 6'd1) smp_d[1] = RX_IN;
      if (edge_q == half)        smp_d[2] = RX_IN;
    end

    case (state_q)
      S_IDLE: begin
        edge_d = 6'd0;
        if (RX_IN) armed_d = 1'b1;
        if (!RX_IN && armed_q) begin
          state_d = S_START;
          edge_d  = 6'd1;
          bit_d   = '0;
          bad_d   = 1'b0;
          pen_d   = PAR_EN;
          ptyp_d  = PAR_TYP;
          presc_d = Prescale;
        end
      end
      S_START: begin
        if (mid && bitv) begin
          state_d = S_IDLE;
          edge_d  = 6'd0;
        end else if (last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (mid) shift_d = {bitv, shift_q[DATA_WIDTH-1:1]};
        if (last) begin
          if (bit_q == BW'(DATA_WIDTH - 1))
            state_d = pen_q ? S_PAR : S_STOP;
          else
            bit_d = bit_q + BW'(1);
        end
      end
      S_PAR: begin
        if (last) begin
          state_d = S_STOP;
          if (bitv != exp_par) begin
            perr_d = 1'b1;
            bad_d  = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (last) begin
          state_d = S_IDLE;
          if (!bitv) begin
            serr_d  = 1'b1;
            armed_d = 1'b0;
          end else if (!bad_q) begin
            pdata_d = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = 6'd0;
      end
    endcase
  end

  // State registers with asynchronous abort
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      pdata_q <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
      bad_q   <= 1'b0;
      armed_q <= 1'b1;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      presc_q <= 6'd8;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      pdata_q <= pdata_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
      bad_q   <= bad_d;
      armed_q <= armed_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      presc_q <= presc_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign data_valid = valid_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;

endmodule
